// File: rtl/load_store_unit_if.sv
// Request/response and 32-bit memory bus bundle for the load/store unit.
// Handshakes: a request transfers on a rising edge where req_valid && req_ready; a bus beat completes on a rising edge where bus_req && bus_ack.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              mem_rw;
    logic [2:0]        size_type;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
    logic              resp_valid;
    logic [63:0]       rdata;
    logic              misaligned;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    // master: the unit itself (serves requests, masters the memory bus)
    modport master (
        input  req_valid, mem_rw, size_type, addr, wdata, bus_ack, bus_rdata,
        output req_ready, resp_valid, rdata, misaligned,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    // slave: the environment (requester plus memory)
    modport slave (
        output req_valid, mem_rw, size_type, addr, wdata, bus_ack, bus_rdata,
        input  req_ready, resp_valid, rdata, misaligned,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request per handshake, executed as one or two beats on a 32-bit req/ack bus
// with byte enables, store lane replication and sign/zero-extended 64-bit load results.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.master lsu,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    logic              lat_rw;
    logic [2:0]        lat_size;
    logic [1:0]        lat_off;
    logic [31:0]       lat_whi;
    logic              bus_req_r;
    logic              bus_we_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [3:0]        bus_be_r;
    logic [31:0]       bus_wdata_r;
    logic              resp_valid_r;
    logic              misaligned_r;
    logic [63:0]       rdata_r;

    logic              is_misaligned;
    logic [3:0]        be_next;
    logic [31:0]       wdata_next;
    logic [31:0]       lane_data;
    logic [63:0]       load_ext;

    // Decode of the incoming request, used only on the accept edge
    always_comb begin
        is_misaligned = 1'b0;
        be_next       = 4'b1111;
        wdata_next    = lsu.wdata[31:0];
        case (lsu.size_type[1:0])
            2'b10: begin
                be_next    = 4'b0001 << lsu.addr[1:0];
                wdata_next = {4{lsu.wdata[7:0]}};
            end
            2'b01: begin
                is_misaligned = lsu.addr[0];
                be_next       = 4'b0011 << lsu.addr[1:0];
                wdata_next    = {2{lsu.wdata[15:0]}};
            end
            2'b00:   is_misaligned = |lsu.addr[1:0];
            default: is_misaligned = |lsu.addr[2:0];
        endcase
    end

    // Single-beat load result; doubles bypass this and store raw halves
    always_comb begin
        lane_data = lsu.bus_rdata >> {lat_off, 3'b000};
        case (lat_size[1:0])
            2'b10:   load_ext = {{56{lat_size[2] & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_ext = {{48{lat_size[2] & lane_data[15]}}, lane_data[15:0]};
            default: load_ext = {{32{lat_size[2] & lane_data[31]}}, lane_data};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_rw       <= 1'b0;
            lat_size     <= 3'd0;
            lat_off      <= 2'd0;
            lat_whi      <= 32'd0;
            bus_req_r    <= 1'b0;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= '0;
            bus_be_r     <= 4'd0;
            bus_wdata_r  <= 32'd0;
            resp_valid_r <= 1'b0;
            misaligned_r <= 1'b0;
            rdata_r      <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu.req_valid) begin
                        lat_rw       <= lsu.mem_rw;
                        lat_size     <= lsu.size_type;
                        lat_off      <= lsu.addr[1:0];
                        lat_whi      <= lsu.wdata[63:32];
                        rdata_r      <= 64'd0;
                        misaligned_r <= is_misaligned;
                        if (is_misaligned) begin
                            state        <= RESP;
                            resp_valid_r <= 1'b1;
                        end else begin
                            state       <= BEAT0;
                            bus_req_r   <= 1'b1;
                            bus_we_r    <= lsu.mem_rw;
                            bus_addr_r  <= {lsu.addr[ADDR_W-1:2], 2'b00};
                            bus_be_r    <= be_next;
                            bus_wdata_r <= wdata_next;
                        end
                    end
                end
                BEAT0: begin
                    if (lsu.bus_ack) begin
                        if (lat_size[1:0] == 2'b11) begin
                            state       <= BEAT1;
                            bus_addr_r  <= bus_addr_r + ADDR_W'(4);
                            bus_wdata_r <= lat_whi;
                            if (!lat_rw) rdata_r[31:0] <= lsu.bus_rdata;
                        end else begin
                            state        <= RESP;
                            bus_req_r    <= 1'b0;
                            bus_we_r     <= 1'b0;
                            bus_be_r     <= 4'd0;
                            bus_wdata_r  <= 32'd0;
                            resp_valid_r <= 1'b1;
                            if (!lat_rw) rdata_r <= load_ext;
                        end
                    end
                end
                BEAT1: begin
                    if (lsu.bus_ack) begin
                        state        <= RESP;
                        bus_req_r    <= 1'b0;
                        bus_we_r     <= 1'b0;
                        bus_be_r     <= 4'd0;
                        bus_wdata_r  <= 32'd0;
                        resp_valid_r <= 1'b1;
                        if (!lat_rw) rdata_r[63:32] <= lsu.bus_rdata;
                    end
                end
                default: begin
                    state        <= IDLE;
                    resp_valid_r <= 1'b0;
                    misaligned_r <= 1'b0;
                end
            endcase
        end
    end

    assign lsu.req_ready  = (state == IDLE);
    assign lsu.resp_valid = resp_valid_r;
    assign lsu.rdata      = rdata_r;
    assign lsu.misaligned = misaligned_r;
    assign lsu.bus_req    = bus_req_r;
    assign lsu.bus_we     = bus_we_r;
    assign lsu.bus_addr   = bus_addr_r;
    assign lsu.bus_be     = bus_be_r;
    assign lsu.bus_wdata  = bus_wdata_r;
    assign state_dbg      = state;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-level reference model, scripted bus memory and a
// per-cycle compare process, plus literal expectations for the documented scenarios.
module tb_load_store_unit;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         errors = 0;
    int         resp_cnt = 0;

    beat_t       exp_beats[$];
    logic [64:0] exp_q[$];
    int          wait_q[$];
    logic [31:0] rd_q[$];

    load_store_unit_if #(.ADDR_W(ADDR_W)) ifc ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lsu       (ifc),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: byte-oriented view of each request -> expected beats and response
    task automatic push_model(input logic rw, input logic [2:0] sz, input logic [31:0] a,
                              input logic [63:0] wd, input int w0, input int w1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              output beat_t b0, output logic [63:0] mr);
        int    n;
        int    off;
        beat_t b;
        n   = (sz[1:0] == 2'b10) ? 1 : (sz[1:0] == 2'b01) ? 2 : (sz[1:0] == 2'b00) ? 4 : 8;
        off = int'(a[1:0]);
        mr  = '0;
        b0  = '0;
        if ((int'(a[2:0]) % n) != 0) begin
            exp_q.push_back({1'b1, 64'd0});
            return;
        end
        b.we   = rw;
        b.addr = {a[31:2], 2'b00};
        b.be   = '0;
        b.wd   = '0;
        for (int i = 0; i < 4; i++) begin
            if (n >= 4 || (i >= off && i < off + n)) b.be[i] = 1'b1;
            b.wd[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        b0 = b;
        exp_beats.push_back(b);
        wait_q.push_back(w0);
        rd_q.push_back(d0);
        if (n == 8) begin
            b.addr = b.addr + 32'd4;
            for (int i = 0; i < 4; i++) b.wd[8*i +: 8] = wd[32 + 8*i +: 8];
            exp_beats.push_back(b);
            wait_q.push_back(w1);
            rd_q.push_back(d1);
        end
        if (rw) begin
            mr = '0;
        end else if (n == 8) begin
            mr = {d1, d0};
        end else begin
            for (int i = 0; i < n; i++) mr[8*i +: 8] = d0[8*(off + i) +: 8];
            if (sz[2] && mr[8*n-1]) begin
                for (int i = n; i < 8; i++) mr[8*i +: 8] = 8'hFF;
            end
        end
        exp_q.push_back({1'b0, mr});
    endtask

    task automatic issue(input logic rw, input logic [2:0] sz, input logic [31:0] a,
                         input logic [63:0] wd, output int waited);
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.mem_rw    = rw;
        ifc.size_type = sz;
        ifc.addr      = a;
        ifc.wdata     = wd;
        waited = 0;
        while (!ifc.req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int lat, input logic [63:0] er, input logic em);
        int   k;
        logic seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            @(negedge clk);
            #2;
            k++;
            if (ifc.resp_valid) seen = 1'b1;
            else chk("req_ready_busy", 64'(ifc.req_ready), 64'd0);
        end
        chk("resp_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("resp_latency", 64'(k), 64'(lat));
            chk("resp_rdata", ifc.rdata, er);
            chk("resp_misaligned", 64'(ifc.misaligned), 64'(em));
        end
    endtask

    task automatic do_txn(input logic rw, input logic [2:0] sz, input logic [31:0] a,
                          input logic [63:0] wd, input int w0, input int w1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input int lat, input logic [63:0] er, input logic em,
                          output beat_t b0, output logic [63:0] mr);
        int waited;
        push_model(rw, sz, a, wd, w0, w1, d0, d1, b0, mr);
        issue(rw, sz, a, wd, waited);
        chk("accept_wait", 64'(waited), 64'd0);
        wait_resp(lat, er, em);
    endtask

    // Bus memory: acks each beat after its scripted number of wait cycles
    initial begin
        forever begin
            @(negedge clk);
            if (ifc.bus_ack) begin
                ifc.bus_ack = 1'b0;
                if (wait_q.size() != 0) begin
                    void'(wait_q.pop_front());
                    void'(rd_q.pop_front());
                end
            end
            if (ifc.bus_req && wait_q.size() != 0) begin
                if (resp_cnt >= wait_q[0]) begin
                    ifc.bus_ack   = 1'b1;
                    ifc.bus_rdata = rd_q[0];
                    resp_cnt      = 0;
                end else begin
                    resp_cnt++;
                end
            end
        end
    end

    // Compare process: bus beats and responses against the model every cycle
    initial begin
        beat_t       b;
        logic [64:0] r;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (ifc.bus_req) begin
                    chk("bus_beat_expected", 64'(exp_beats.size() != 0), 64'd1);
                    if (exp_beats.size() != 0) begin
                        b = exp_beats[0];
                        chk("bus_we", 64'(ifc.bus_we), 64'(b.we));
                        chk("bus_addr", 64'(ifc.bus_addr), 64'(b.addr));
                        chk("bus_be", 64'(ifc.bus_be), 64'(b.be));
                        if (b.we) chk("bus_wdata", 64'(ifc.bus_wdata), 64'(b.wd));
                        if (ifc.bus_ack) void'(exp_beats.pop_front());
                    end
                end else begin
                    chk("bus_idle_zero", {27'd0, ifc.bus_we, ifc.bus_be, ifc.bus_wdata}, 64'd0);
                end
                if (ifc.resp_valid) begin
                    chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        r = exp_q.pop_front();
                        chk("model_rdata", ifc.rdata, r[63:0]);
                        chk("model_misaligned", 64'(ifc.misaligned), 64'(r[64]));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t       b0;
        logic [63:0] mr;
        logic [63:0] mr2;
        int          waited;
        int          k;
        ifc.req_valid = 1'b0;
        ifc.mem_rw    = 1'b0;
        ifc.size_type = 3'd0;
        ifc.addr      = '0;
        ifc.wdata     = '0;
        ifc.bus_ack   = 1'b0;
        ifc.bus_rdata = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_req_ready", 64'(ifc.req_ready), 64'd1);
        chk("reset_bus_req", 64'(ifc.bus_req), 64'd0);
        chk("reset_resp_valid", 64'(ifc.resp_valid), 64'd0);
        chk("reset_rdata", ifc.rdata, 64'd0);
        chk("reset_bus_addr", 64'(ifc.bus_addr), 64'd0);
        chk("reset_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1 lb at byte 3, negative byte
        do_txn(1'b0, 3'b110, 32'h103, 64'd0, 0, 0, 32'h80123456, 32'd0, 2,
               64'hFFFF_FFFF_FFFF_FF80, 1'b0, b0, mr);
        chk("pin_t1_be", 64'(b0.be), 64'h8);
        chk("pin_t1_rdata", mr, 64'hFFFF_FFFF_FFFF_FF80);
        // T2 sh at halfword 1
        do_txn(1'b1, 3'b001, 32'h102, 64'h12345678_DEADBEEF, 0, 0, 32'd0, 32'd0, 2,
               64'd0, 1'b0, b0, mr);
        chk("pin_t2_wdata", 64'(b0.wd), 64'hBEEF_BEEF);
        chk("pin_t2_be", 64'(b0.be), 64'hC);
        // T3 ld with two wait cycles per beat
        do_txn(1'b0, 3'b011, 32'h200, 64'd0, 2, 2, 32'h11223344, 32'h55667788, 7,
               64'h55667788_11223344, 1'b0, b0, mr);
        chk("pin_t3_addr", 64'(b0.addr), 64'h200);
        chk("pin_t3_rdata", mr, 64'h55667788_11223344);
        // T4 misaligned lw
        do_txn(1'b0, 3'b000, 32'h102, 64'd0, 0, 0, 32'd0, 32'd0, 1, 64'd0, 1'b1, b0, mr);
        // Further patterns
        do_txn(1'b1, 3'b010, 32'h101, 64'hA5, 0, 0, 32'd0, 32'd0, 2, 64'd0, 1'b0, b0, mr);
        chk("pin_sb_be", 64'(b0.be), 64'h2);
        do_txn(1'b0, 3'b110, 32'h102, 64'd0, 3, 0, 32'h127F0000, 32'd0, 5, 64'h7F, 1'b0, b0, mr);
        do_txn(1'b0, 3'b101, 32'h100, 64'd0, 0, 0, 32'h00008001, 32'd0, 2,
               64'hFFFF_FFFF_FFFF_8001, 1'b0, b0, mr);
        do_txn(1'b0, 3'b100, 32'h104, 64'd0, 0, 0, 32'h80000000, 32'd0, 2,
               64'hFFFF_FFFF_8000_0000, 1'b0, b0, mr);
        do_txn(1'b0, 3'b000, 32'h104, 64'd0, 1, 0, 32'h80000000, 32'd0, 3,
               64'h0000_0000_8000_0000, 1'b0, b0, mr);
        do_txn(1'b0, 3'b111, 32'h208, 64'd0, 0, 1, 32'hDEADBEEF, 32'hFFFFFFFF, 4,
               64'hFFFF_FFFF_DEAD_BEEF, 1'b0, b0, mr);
        do_txn(1'b1, 3'b011, 32'h310, 64'h01234567_89ABCDEF, 1, 0, 32'd0, 32'd0, 4,
               64'd0, 1'b0, b0, mr);
        do_txn(1'b1, 3'b011, 32'h304, 64'h1, 0, 0, 32'd0, 32'd0, 1, 64'd0, 1'b1, b0, mr);
        do_txn(1'b0, 3'b001, 32'h101, 64'd0, 0, 0, 32'd0, 32'd0, 1, 64'd0, 1'b1, b0, mr);

        // T5 reset while the second store beat waits for ack
        push_model(1'b1, 3'b011, 32'h300, 64'hAAAA5555_CCCC3333, 0, 1000, 32'd0, 32'd0, b0, mr);
        issue(1'b1, 3'b011, 32'h300, 64'hAAAA5555_CCCC3333, waited);
        k = 0;
        while (!(ifc.bus_req && ifc.bus_addr == 32'h304) && k < 20) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("t5_in_beat1", 64'(ifc.bus_req && ifc.bus_addr == 32'h304), 64'd1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_bus_req_drop", 64'(ifc.bus_req), 64'd0);
        chk("t5_resp_valid", 64'(ifc.resp_valid), 64'd0);
        chk("t5_state", 64'(state_dbg), 64'd0);
        exp_beats.delete();
        exp_q.delete();
        wait_q.delete();
        rd_q.delete();
        ifc.bus_ack = 1'b0;
        resp_cnt    = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #2;
            chk("t5_no_resp", 64'(ifc.resp_valid), 64'd0);
            chk("t5_req_ready", 64'(ifc.req_ready), 64'd1);
        end

        // T6 lhu with the next lw held on req_valid while busy
        push_model(1'b0, 3'b001, 32'h106, 64'd0, 0, 0, 32'hF00D1234, 32'd0, b0, mr);
        chk("pin_t6_rdata", mr, 64'h0000_0000_0000_F00D);
        push_model(1'b0, 3'b000, 32'h108, 64'd0, 0, 0, 32'hCAFEF00D, 32'd0, b0, mr2);
        issue(1'b0, 3'b001, 32'h106, 64'd0, waited);
        chk("t6_first_accept", 64'(waited), 64'd0);
        ifc.mem_rw    = 1'b0;
        ifc.size_type = 3'b000;
        ifc.addr      = 32'h108;
        ifc.wdata     = 64'd0;
        ifc.req_valid = 1'b1;
        wait_resp(2, 64'h0000_0000_0000_F00D, 1'b0);
        issue(1'b0, 3'b000, 32'h108, 64'd0, waited);
        chk("t6_second_accept", 64'(waited), 64'd0);
        wait_resp(2, 64'h0000_0000_CAFE_F00D, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_beats_drained", 64'(exp_beats.size()), 64'd0);
        chk("final_resp_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
